core_pipe: RTL
==============

// Module: core_pipe
// PURPOSE
//  Parametrised 3-stage (F/E/W) in-order integer core, successor to the single-issue core.
//  Fetches over a req/valid instruction-memory handshake instead of a hardwired cache.
//  Decodes and executes in E, with W->E forwarding and branch flush. Writes back in W.
//  Sits between the instruction memory and the debug/trace logic; no data memory port.
// PARAMETERS
//  XLEN      32  datapath / register width (>=32)
//  PC_W      16  program counter width, word-addressed
//  NREG      32  architectural registers; r0 reads 0, ignores writes
//  RESET_PC  10  PC loaded on reset
// PORTS
//  clk          in   1      core clock, single domain
//  rst          in   1      synchronous, active-high reset
//  clk_en       in   1      global advance; 0 freezes all state, outputs held
//  imem_req     out  1      fetch request; held with imem_addr stable until imem_valid
//  imem_addr    out  PC_W   word address of the fetch
//  imem_valid   in   1      imem_rdata valid this cycle; >=1 cycle after req
//  imem_rdata   in   32     instruction word
//  wb_valid     out  1      register write this cycle
//  wb_addr      out  5      destination register
//  wb_data      out  XLEN   write data
//  illegal_op   out  1      1-cycle pulse: E held an unsupported opcode/funct
// BEHAVIOUR
//  - Reset: pc=RESET_PC; F/E/W valids=0; imem_req=0 in the reset cycle, 1 from the next cycle.
//    wb_valid=0, wb_addr=0, wb_data=0, illegal_op=0. Register file cleared to 0.
//  - Fetch handshake:
//    - One request outstanding at a time.
//    - When imem_valid=1 and the fetch is not killed: instr and pc go into E (e_valid=1), pc<=pc+1.
//    - A new request starts the next cycle.
//    - When imem_valid=0, E receives a bubble.
//  - Decode in E (MIPS fields):
//    - op=0 R-type. funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x2A SLT (signed).
//    - op=8 ADDI: rt = rs + sext(imm16).
//    - op=15 LUI: rt = {imm16, 16'b0}, zero-extended to XLEN.
//    - op=2 J: pc <= imm26[PC_W-1:0].
//    - op=4 BEQ: if rs==rt, pc <= e_pc + 1 + sext(imm16), truncated mod 2^PC_W.
//  - Arithmetic wraps at XLEN; no overflow trap. PC wraps at 2^PC_W.
//  - Unsupported op/funct: treated as NOP, illegal_op pulses 1 cycle, pipeline continues.
//  - Writes to r0 (rd/rt==0) are suppressed: wb_valid stays 0.
//  - Latency: result visible on wb_* 2 cycles after imem_valid; the regfile updates on that edge.
//  - Forwarding: if W is writing rN and E reads rN, E uses wb_data.
//    - A same-edge write followed by read sees the new value, so there are no stalls.
//  - Taken J/BEQ in E:
//    - pc <= target.
//    - The instruction arriving with imem_valid in the same cycle is discarded.
//    - If a request is outstanding, a kill flag drops its response; the new request issues after it returns.
//    - Net penalty: 1 bubble minimum.
//  - clk_en=0 has priority over everything except rst: no state changes.
//    - imem_req/imem_addr are held.
//    - imem_valid seen while clk_en=0 is ignored; memory must hold it.
//  - rst mid-fetch: the outstanding request is abandoned and the kill flag is cleared.
//    - Responses arriving within the first cycle after reset are ignored.
// CONFIGURATION
//  CORE_RETIRE_PORT_EN
//  - Defined: adds output ports retire_valid (1) and retire_pc (PC_W).
//    - These pulse once per instruction leaving W, NOPs and illegals included.
//    - Reset value 0.
//  - Undefined: these ports and their pipeline registers are absent; all other behaviour is identical.
// STRUCTURE
//  - core_pkg: opcode/funct localparams (OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LUI, FN_*).
//    Also the decoded-instruction struct typedef and the ALU-op enum.
//  - Sub-module core_pipe_regfile: 2 read ports combinational, 1 write port synchronous.
//    r0 = 0, depth NREG.
//  - ALU, decode, hazard/flush logic stay inline.
// TESTING
//  - Reset: rst=1 for 2 cycles -> imem_addr=10, wb_valid=0. One cycle after release, imem_req=1.
//  - ADDI r1,r0,5 then ADDI r2,r1,3 back-to-back, imem_valid every cycle:
//    wb r1=5, then r2=8 the next cycle (forwarding), no bubble.
//  - LUI r3,0x1234 -> wb_data=0x12340000. ADDI r0,r0,7 -> wb_valid stays 0.
//  - BEQ r0,r0,+4 at pc=20 -> next fetched imem_addr=25. The instruction from pc=21 never writes back.
//  - imem_valid delayed 3 cycles -> imem_addr held stable, 3 bubbles, no duplicate wb.
//  - SUB with r1=0, r2=1 -> 0xFFFFFFFF. Opcode 0x3F -> illegal_op=1 for 1 cycle, no write.

Source files
------------

// File: rtl/core_pkg.sv
// Shared opcode/funct encodings, ALU op enum and decoded-instruction struct for core_pipe.
package core_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_LUI
    } alu_op_e;

    typedef struct packed {
        alu_op_e     alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wa;
        logic        wen;
        logic        use_imm;
        logic        is_j;
        logic        is_beq;
        logic        illegal;
        logic [15:0] imm;
        logic [25:0] imm26;
    } dec_t;

    // Unsupported encodings decode to a non-writing NOP with the illegal flag set.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d       = '0;
        d.rs    = ins[25:21];
        d.rt    = ins[20:16];
        d.imm   = ins[15:0];
        d.imm26 = ins[25:0];
        case (ins[31:26])
            OP_RTYPE: begin
                d.wa  = ins[15:11];
                d.wen = 1'b1;
                case (ins[5:0])
                    FN_ADD:  d.alu = ALU_ADD;
                    FN_SUB:  d.alu = ALU_SUB;
                    FN_AND:  d.alu = ALU_AND;
                    FN_OR:   d.alu = ALU_OR;
                    FN_XOR:  d.alu = ALU_XOR;
                    FN_SLT:  d.alu = ALU_SLT;
                    default: begin
                        d.wen     = 1'b0;
                        d.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                d.wa      = ins[20:16];
                d.wen     = 1'b1;
                d.use_imm = 1'b1;
                d.alu     = ALU_ADD;
            end
            OP_LUI: begin
                d.wa  = ins[20:16];
                d.wen = 1'b1;
                d.alu = ALU_LUI;
            end
            OP_J:    d.is_j    = 1'b1;
            OP_BEQ:  d.is_beq  = 1'b1;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/core_pipe_regfile.sv
// Register file: two combinational read ports, one synchronous write port, r0 hardwired to 0.
module core_pipe_regfile
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr_a_i,
    input  logic [4:0]      raddr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/core_pipe.sv
// 3-stage F/E/W in-order integer core with W->E forwarding and branch flush.
// Optional retire trace ports enabled by defining CORE_RETIRE_PORT_EN.
module core_pipe
    import core_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PC_W     = 16,
    parameter int unsigned NREG     = 32,
    parameter int unsigned RESET_PC = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal_op
`ifdef CORE_RETIRE_PORT_EN
    ,
    output logic            retire_valid,
    output logic [PC_W-1:0] retire_pc
`endif
);

    logic [PC_W-1:0] pc_q, pc_d, tgt_q, tgt_d, e_pc_q, e_pc_d;
    logic            req_q, kill_q, kill_d, e_valid_q, e_valid_d;
    logic [31:0]     e_instr_q, e_instr_d;
    logic            wb_valid_q, wb_valid_d, illegal_q, illegal_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    dec_t            dec;
    logic [XLEN-1:0] rs_rf, rt_rf, rs_val, rt_val, opb, imm_sx;
    logic [31:0]     br_sum, j_full;
    logic [PC_W-1:0] target;
    logic            taken, resp, unused_ok;

    assign dec = decode(e_instr_q);

    core_pipe_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wb_valid_q && clk_en),
        .waddr_i   (wb_addr_q),
        .wdata_i   (wb_data_q),
        .raddr_a_i (dec.rs),
        .raddr_b_i (dec.rt),
        .rdata_a_o (rs_rf),
        .rdata_b_o (rt_rf)
    );

    // W never holds a valid write to r0, so a plain address match is enough to forward.
    assign rs_val = (wb_valid_q && (wb_addr_q == dec.rs)) ? wb_data_q : rs_rf;
    assign rt_val = (wb_valid_q && (wb_addr_q == dec.rt)) ? wb_data_q : rt_rf;
    assign imm_sx = {{(XLEN-16){dec.imm[15]}}, dec.imm};
    assign opb    = dec.use_imm ? imm_sx : rt_val;

    assign br_sum    = 32'(e_pc_q) + 32'd1 + {{16{dec.imm[15]}}, dec.imm};
    assign j_full    = 32'(dec.imm26);
    assign target    = dec.is_j ? j_full[PC_W-1:0] : br_sum[PC_W-1:0];
    assign taken     = e_valid_q && (dec.is_j || (dec.is_beq && (rs_val == rt_val)));
    assign resp      = req_q && imem_valid;
    assign unused_ok = ^{br_sum[31:PC_W], j_full[31:PC_W]};

    // Fetch/redirect: a taken branch either retargets immediately or arms the kill flag.
    always_comb begin
        pc_d      = pc_q;
        kill_d    = kill_q;
        tgt_d     = tgt_q;
        e_valid_d = 1'b0;
        e_instr_d = e_instr_q;
        e_pc_d    = e_pc_q;
        if (taken) begin
            if (resp || !req_q) begin
                pc_d   = target;
                kill_d = 1'b0;
            end else begin
                kill_d = 1'b1;
                tgt_d  = target;
            end
        end else if (resp) begin
            if (kill_q) begin
                kill_d = 1'b0;
                pc_d   = tgt_q;
            end else begin
                e_valid_d = 1'b1;
                e_instr_d = imem_rdata;
                e_pc_d    = pc_q;
                pc_d      = pc_q + PC_W'(1);
            end
        end
    end

    // Execute: ALU result and write-back/illegal flags for the W stage.
    always_comb begin
        wb_data_d = '0;
        case (dec.alu)
            ALU_ADD: wb_data_d = rs_val + opb;
            ALU_SUB: wb_data_d = rs_val - opb;
            ALU_AND: wb_data_d = rs_val & opb;
            ALU_OR:  wb_data_d = rs_val | opb;
            ALU_XOR: wb_data_d = rs_val ^ opb;
            ALU_SLT: wb_data_d = ($signed(rs_val) < $signed(opb)) ? XLEN'(1) : '0;
            ALU_LUI: wb_data_d = XLEN'({dec.imm, 16'h0000});
            default: wb_data_d = '0;
        endcase
        wb_valid_d = e_valid_q && dec.wen && (dec.wa != 5'd0);
        wb_addr_d  = dec.wa;
        illegal_d  = e_valid_q && dec.illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= PC_W'(RESET_PC);
            req_q      <= 1'b0;
            kill_q     <= 1'b0;
            tgt_q      <= '0;
            e_valid_q  <= 1'b0;
            e_instr_q  <= '0;
            e_pc_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else if (clk_en) begin
            pc_q       <= pc_d;
            req_q      <= 1'b1;
            kill_q     <= kill_d;
            tgt_q      <= tgt_d;
            e_valid_q  <= e_valid_d;
            e_instr_q  <= e_instr_d;
            e_pc_q     <= e_pc_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign wb_valid   = wb_valid_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign illegal_op = illegal_q;

`ifdef CORE_RETIRE_PORT_EN
    logic            ret_valid_q;
    logic [PC_W-1:0] ret_pc_q;

    // Every instruction that reaches W is traced, including NOPs and illegals.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_valid_q <= 1'b0;
            ret_pc_q    <= '0;
        end else if (clk_en) begin
            ret_valid_q <= e_valid_q;
            ret_pc_q    <= e_pc_q;
        end
    end

    assign retire_valid = ret_valid_q;
    assign retire_pc    = ret_pc_q;
`endif

endmodule
